// File: rtl/hid_report_arbiter_if.sv
// hid_report_arbiter_if: report inputs from the HID hosts and the shared display
// register outputs of hid_report_arbiter, bundled with host/arbiter modports.
interface hid_report_arbiter_if #(
    parameter int C_sources      = 2,
    parameter int C_report_bytes = 8,
    parameter int C_disp_bits    = 256
);
    localparam int RW = C_report_bytes * 8;

    logic [C_sources-1:0]    src_valid;
    logic [C_sources*RW-1:0] src_report;
    logic [C_disp_bits-1:0]  disp_data;
    logic                    disp_wr;
    logic [1:0]              grant_src;
    logic [C_sources-1:0]    stale;
    logic [C_sources-1:0]    overrun;

    // Host side: drives reports, observes the display register
    modport master (
        output src_valid, src_report,
        input  disp_data, disp_wr, grant_src, stale, overrun
    );

    // Arbiter side
    modport slave (
        input  src_valid, src_report,
        output disp_data, disp_wr, grant_src, stale, overrun
    );
endinterface

// File: rtl/hid_report_arbiter.sv
// hid_report_arbiter: buffers one HID report per source, writes them round-robin
// into per-source slots of a shared display register and clears slots of silent hosts.
module hid_report_arbiter #(
    parameter int C_sources      = 2,
    parameter int C_report_bytes = 8,
    parameter int C_disp_bits    = 256,
    parameter int C_timeout_bits = 22
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    hid_report_arbiter_if.slave bus
);
    localparam int RW = C_report_bytes * 8;
    localparam int SW = C_sources * RW;
    localparam logic [C_timeout_bits-1:0] TMO_MAX = '1;
    localparam logic [C_timeout_bits-1:0] TMO_PRE = TMO_MAX - 1'b1;

    typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, CLEAR = 2'd2} state_t;

    state_t                    state_r;
    state_t                    state_s;
    logic [3:0]                valid_s;
    logic [3:0]                pend_r;
    logic [3:0]                clr_ext_s;
    logic [C_sources-1:0]      clr_req_r;
    logic [C_sources-1:0]      stale_r;
    logic [C_sources-1:0]      overrun_r;
    logic [C_timeout_bits-1:0] tmo_r [C_sources];
    logic [SW-1:0]             rpt_buf_r;
    logic [SW-1:0]             slots_r;
    logic [RW-1:0]             hold_r;
    logic [1:0]                rr_r;
    logic [1:0]                sel_r;
    logic [1:0]                grant_src_r;
    logic [1:0]                pick_s;
    logic [1:0]                clr_pick_s;
    logic                      pick_vld_s;
    logic                      clr_any_s;
    logic                      grant_s;
    logic                      start_clear_s;
    logic                      xfer_s;
    logic                      clear_s;
    logic                      disp_wr_r;

    // Widen per-source vectors to 4 lanes so 2-bit indices always fit; unused lanes stay 0
    always_comb begin
        valid_s                  = 4'b0000;
        valid_s[C_sources-1:0]   = bus.src_valid;
        clr_ext_s                = 4'b0000;
        clr_ext_s[C_sources-1:0] = clr_req_r;
    end

    // Round-robin pick: first pending source after rr_r (nearest candidate evaluated last wins)
    always_comb begin
        logic [2:0] cand_v;
        pick_s     = rr_r;
        pick_vld_s = 1'b0;
        cand_v     = 3'd0;
        for (int i = C_sources; i >= 1; i--) begin
            cand_v     = {1'b0, rr_r} + 3'(i);
            cand_v     = (cand_v >= 3'(C_sources)) ? (cand_v - 3'(C_sources)) : cand_v;
            pick_s     = pend_r[cand_v[1:0]] ? cand_v[1:0] : pick_s;
            pick_vld_s = pend_r[cand_v[1:0]] | pick_vld_s;
        end
    end

    // Lowest-index source with an outstanding clear request
    always_comb begin
        clr_pick_s = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            clr_pick_s = clr_ext_s[i] ? 2'(i) : clr_pick_s;
        end
        clr_any_s = |clr_ext_s;
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state: reports always beat clears
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (pick_vld_s) begin
                    state_s = XFER;
                end else if (clr_any_s) begin
                    state_s = CLEAR;
                end else begin
                    state_s = IDLE;
                end
            end
            XFER:    state_s = IDLE;
            CLEAR:   state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FSM decoded controls
    always_comb begin
        grant_s       = 1'b0;
        start_clear_s = 1'b0;
        xfer_s        = 1'b0;
        clear_s       = 1'b0;
        case (state_r)
            IDLE: begin
                grant_s       = pick_vld_s;
                start_clear_s = !pick_vld_s && clr_any_s;
            end
            XFER:    xfer_s  = 1'b1;
            CLEAR:   clear_s = 1'b1;
            default: grant_s = 1'b0;
        endcase
    end

    // Per-source capture, overrun, stale flag and saturating silence timer
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            pend_r    <= 4'b0000;
            stale_r   <= '0;
            overrun_r <= '0;
            clr_req_r <= '0;
            rpt_buf_r <= '0;
            for (int k = 0; k < C_sources; k++) begin
                tmo_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (valid_s[k]) begin
                    pend_r[k] <= 1'b1;
                end else if (grant_s && (pick_s == 2'(k))) begin
                    pend_r[k] <= 1'b0;
                end
            end
            for (int k = 0; k < C_sources; k++) begin
                if (valid_s[k]) begin
                    rpt_buf_r[k*RW +: RW] <= bus.src_report[k*RW +: RW];
                    tmo_r[k]              <= '0;
                    stale_r[k]            <= 1'b0;
                    // a report granted this very cycle leaves with the old copy; no loss
                    if (pend_r[k] && !(grant_s && (pick_s == 2'(k)))) begin
                        overrun_r[k] <= 1'b1;
                    end
                end else begin
                    if (clear_s && (sel_r == 2'(k))) begin
                        stale_r[k] <= 1'b1;
                    end
                    if (!pend_r[k] && !stale_r[k] && (tmo_r[k] != TMO_MAX)) begin
                        tmo_r[k] <= tmo_r[k] + 1'b1;
                    end
                end
                // raise once, on the step into all-ones
                if (clear_s && (sel_r == 2'(k))) begin
                    clr_req_r[k] <= 1'b0;
                end else if (!valid_s[k] && !pend_r[k] && !stale_r[k] && (tmo_r[k] == TMO_PRE)) begin
                    clr_req_r[k] <= 1'b1;
                end
            end
        end
    end

    // Grant latch, round-robin pointer and slot writes
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            rr_r        <= 2'(C_sources - 1);
            sel_r       <= 2'd0;
            hold_r      <= '0;
            slots_r     <= '0;
            grant_src_r <= 2'd0;
            disp_wr_r   <= 1'b0;
        end else begin
            disp_wr_r <= xfer_s | clear_s;
            if (grant_s) begin
                sel_r  <= pick_s;
                rr_r   <= pick_s;
                hold_r <= rpt_buf_r[int'(pick_s)*RW +: RW];
            end else if (start_clear_s) begin
                sel_r <= clr_pick_s;
            end
            if (xfer_s) begin
                slots_r[int'(sel_r)*RW +: RW] <= hold_r;
                grant_src_r                   <= sel_r;
            end else if (clear_s) begin
                slots_r[int'(sel_r)*RW +: RW] <= '0;
            end
        end
    end

    // Display bits above the populated slots are tied to zero
    always_comb begin
        bus.disp_data         = '0;
        bus.disp_data[SW-1:0] = slots_r;
    end

    assign bus.disp_wr   = disp_wr_r;
    assign bus.grant_src = grant_src_r;
    assign bus.stale     = stale_r;
    assign bus.overrun   = overrun_r;
endmodule
